// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding, opcode field width, default reset PC.
package if_fetch_stage_pkg;

   // FETCH: request outstanding; HOLD: word presented to decode;
   // DRAIN: redirected while a request was in flight, waiting to discard it.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

   // The opcode occupies the top OPCODE_W bits of every instruction word.
   localparam int OPCODE_W = 6;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundles the instruction-memory and decode-side handshakes of the fetch stage.
// Latency: n/a (wires only).
// Backpressure: imem via req/ack, decode via instr_valid/instr_ready.
// master = fetch stage side, slave = memory + decode side.
interface if_fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import if_fetch_stage_pkg::*;

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_o;
   logic [OPCODE_W-1:0] opcode_o;
   logic [ADDR_W-1:0] pc_o;
   logic [ADDR_W-1:0] pc_plus4_o;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output instr_valid, instr_o, opcode_o, pc_o, pc_plus4_o,
      input  instr_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  instr_valid, instr_o, opcode_o, pc_o, pc_plus4_o,
      output instr_ready
   );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter: reset load, +4 step and redirect load (redirect wins over step).
// Latency: new value visible the cycle after the controlling strobe.
// Backpressure: none; the caller only asserts inc when a word is really taken.
// Ports: clk, rst_n (sync, active-low), inc, redirect, target, pc.
module if_fetch_stage_pc_reg #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         // Low two bits are forced to zero; no alignment trap exists.
         pc <= target & ~ADDR_W'(3);
      end else if (inc) begin
         pc <= pc + ADDR_W'(4);
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one imem read at a time, word + PC presented to decode, PC redirects.
// Latency: req in the first cycle out of reset; instr_valid rises the cycle after imem_ack.
// Backpressure: holds the word (no new req) until instr_ready; a redirect discards in-flight data.
// Ports: clk, rst_n, pcsrc_i, target_i, bus (master: imem req/addr/ack/rdata, instr valid/ready/data/pc).
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pcsrc_i,
   input  logic [ADDR_W-1:0] target_i,
   if_fetch_stage_if.master  bus
);

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] drain_addr;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_plus4_q;
   logic [DATA_W-1:0] instr_q;
   logic              valid_q;
   logic              take;
   logic              to_drain;
   logic              req;
   logic [ADDR_W-1:0] addr;

   // A returning word is kept only if no redirect arrives in the same cycle.
   assign take     = (state == ST_FETCH) && bus.imem_ack && !pcsrc_i;
   assign to_drain = (state == ST_FETCH) && !bus.imem_ack && pcsrc_i;

   if_fetch_stage_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (take),
      .redirect (pcsrc_i),
      .target   (target_i),
      .pc       (pc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: begin
            if (to_drain)            state_nxt = ST_DRAIN;
            else if (take)           state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            // valid is always set in HOLD, so ready alone completes the handshake.
            if (pcsrc_i || bus.instr_ready) state_nxt = ST_FETCH;
         end
         ST_DRAIN: begin
            // The stale word is discarded; pc already holds the newest target.
            if (bus.imem_ack)        state_nxt = ST_FETCH;
         end
         default:                    state_nxt = ST_FETCH;
      endcase
   end

   // Memory-side outputs
   always_comb begin
      req  = 1'b0;
      addr = pc;
      case (state)
         ST_FETCH: req = 1'b1;
         ST_DRAIN: begin
            // pc has already moved to the target; keep the address the memory is serving.
            req  = 1'b1;
            addr = drain_addr;
         end
         default:  req = 1'b0;
      endcase
      if (!rst_n) req = 1'b0;
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = addr;

   always_ff @(posedge clk) begin
      if (!rst_n)        drain_addr <= '0;
      else if (to_drain) drain_addr <= pc;
   end

   // Decode-side output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         pc_plus4_q <= '0;
      end else if (take) begin
         valid_q    <= 1'b1;
         instr_q    <= bus.imem_rdata;
         pc_q       <= pc;
         pc_plus4_q <= pc + ADDR_W'(4);
      end else if ((state == ST_HOLD) && (pcsrc_i || bus.instr_ready)) begin
         valid_q    <= 1'b0;
      end
   end

   assign bus.instr_valid = valid_q;
   assign bus.instr_o     = instr_q;
   assign bus.opcode_o    = instr_q[DATA_W-1 -: OPCODE_W];
   assign bus.pc_o        = pc_q;
   assign bus.pc_plus4_o  = pc_plus4_q;

endmodule
